// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: state encodings, stall vectors and bus widths.
package pipe_ctrl_pkg;

  localparam int unsigned RegBus = 32;
  localparam logic [RegBus-1:0] ZeroWord = '0;

  // Stall vector bits: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB.
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallMem  = 6'b011111;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StMstall = 2'd1,
    StFlush  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prioritised stall/flush decode, memory-stall timeout and stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [RegBus-1:0] EXC_VECTOR     = 32'h0000_0020,
  parameter logic [RegBus-1:0] ERET_TYPE      = 32'h0000_000e
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic [RegBus-1:0] excepttype_i,
  input  logic [RegBus-1:0] cp0_epc_i,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [RegBus-1:0] new_pc,
  output logic              bus_abort,
  output logic [31:0]       stall_cnt
);

  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] tmo_q, tmo_d;
  logic       timeout;
  logic       exc;

  assign timeout = stallreq_mem && (tmo_q == TmoLast);
  assign exc     = (excepttype_i != ZeroWord);

  always_comb begin
    stall     = StallNone;
    flush     = 1'b0;
    new_pc    = ZeroWord;
    bus_abort = 1'b0;
    state_d   = StRun;
    tmo_d     = '0;
    if (rst) begin
      // Outputs stay quiet; registers are cleared by the state flops.
    end else if (timeout) begin
      flush     = 1'b1;
      new_pc    = EXC_VECTOR;
      bus_abort = 1'b1;
      state_d   = StFlush;
    end else if (exc) begin
      flush   = 1'b1;
      new_pc  = (excepttype_i == ERET_TYPE) ? cp0_epc_i : EXC_VECTOR;
      state_d = StFlush;
    end else if (stallreq_mem) begin
      stall   = StallMem;
      state_d = StMstall;
      // First stall cycle counts as one so the timeout fires on cycle TIMEOUT_CYCLES.
      tmo_d   = (state_q == StMstall) ? tmo_q + 8'd1 : 8'd1;
    end else if (stallreq_ex) begin
      stall = StallEx;
    end else if (stallreq_id) begin
      stall = StallId;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  sat_counter32 u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall[0]),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with a short timeout of 4 cycles.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush, bus_abort;
  logic [31:0] new_pc, stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(
    .TIMEOUT_CYCLES (4),
    .EXC_VECTOR     (32'h0000_0020),
    .ERET_TYPE      (32'h0000_000e)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excepttype_i (excepttype_i),
    .cp0_epc_i    (cp0_epc_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .bus_abort    (bus_abort),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then drive new inputs away from the edge.
  task automatic step(input logic r, input logic id, input logic ex, input logic mem,
                      input logic [31:0] exc, input logic [31:0] epc);
    @(posedge clk);
    #1;
    rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    excepttype_i = exc; cp0_epc_i = epc;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [5:0] s, input logic f,
                         input logic [31:0] pc, input logic ba);
    chk({tag, ".stall"}, {26'd0, stall}, {26'd0, s});
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, f});
    chk({tag, ".new_pc"}, new_pc, pc);
    chk({tag, ".bus_abort"}, {31'd0, bus_abort}, {31'd0, ba});
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    excepttype_i = 0; cp0_epc_i = 0;
    // Reset with every request active: all outputs must stay quiet.
    step(1, 1, 1, 1, 32'h1, 32'h0);
    chk_out("reset_req", 6'b000000, 0, 32'h0, 0);
    step(1, 0, 0, 0, 32'h0, 32'h0);
    chk("reset_cnt", stall_cnt, 32'd0);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    chk_out("idle", 6'b000000, 0, 32'h0, 0);

    // Single-cycle decode stall.
    step(0, 1, 0, 0, 32'h0, 32'h0);
    chk_out("id_stall", 6'b000111, 0, 32'h0, 0);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    chk_out("id_release", 6'b000000, 0, 32'h0, 0);
    chk("id_cnt", stall_cnt, 32'd1);

    // Execute beats decode; memory beats execute.
    step(0, 1, 1, 0, 32'h0, 32'h0);
    chk_out("ex_id", 6'b001111, 0, 32'h0, 0);
    step(0, 0, 1, 1, 32'h0, 32'h0);
    chk_out("mem_ex", 6'b011111, 0, 32'h0, 0);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    chk("cnt3", stall_cnt, 32'd3);

    // Exception beats memory stall; next cycle back to run.
    step(0, 0, 0, 1, 32'h1, 32'h0);
    chk_out("exc_mem", 6'b000000, 1, 32'h20, 0);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    chk_out("exc_after", 6'b000000, 0, 32'h0, 0);

    // Eret returns to EPC.
    step(0, 0, 0, 0, 32'he, 32'h0000_1234);
    chk_out("eret", 6'b000000, 1, 32'h0000_1234, 0);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    chk("flush_not_counted", stall_cnt, 32'd3);

    // Memory stall held: three stall cycles then timeout on the fourth.
    step(0, 0, 0, 1, 32'h0, 32'h0);
    chk_out("tmo_c1", 6'b011111, 0, 32'h0, 0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    chk_out("tmo_c2", 6'b011111, 0, 32'h0, 0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    chk_out("tmo_c3", 6'b011111, 0, 32'h0, 0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    chk_out("tmo_c4", 6'b000000, 1, 32'h20, 1);
    chk("tmo_cnt", stall_cnt, 32'd6);
    // Request still high after the flush stalls again without another abort.
    step(0, 0, 0, 1, 32'h0, 32'h0);
    chk_out("tmo_c5", 6'b011111, 0, 32'h0, 0);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    chk("tmo_c5_cnt", stall_cnt, 32'd7);

    // Exception inside a memory stall restarts the timeout count.
    step(0, 0, 0, 1, 32'h0, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    step(0, 0, 0, 1, 32'h4, 32'h0);
    chk_out("exc_in_mstall", 6'b000000, 1, 32'h20, 0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    chk_out("restart_c1", 6'b011111, 0, 32'h0, 0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    chk_out("restart_c3", 6'b011111, 0, 32'h0, 0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    chk_out("restart_c4", 6'b000000, 1, 32'h20, 1);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    chk("restart_cnt", stall_cnt, 32'd12);

    // Reset on the second cycle of a memory stall.
    step(0, 0, 0, 1, 32'h0, 32'h0);
    chk_out("rst_mid_c1", 6'b011111, 0, 32'h0, 0);
    step(1, 0, 0, 1, 32'h0, 32'h0);
    chk_out("rst_mid_c2", 6'b000000, 0, 32'h0, 0);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    chk_out("rst_after", 6'b000000, 0, 32'h0, 0);
    chk("rst_after_cnt", stall_cnt, 32'd0);
    // Fresh stall after reset: full three cycles before timeout.
    step(0, 0, 0, 1, 32'h0, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    chk_out("post_rst_c3", 6'b011111, 0, 32'h0, 0);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    chk("post_rst_cnt", stall_cnt, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
